cond_beat_tx: RTL and testbench
===============================

# cond_beat_tx

Command-driven transmitter for the conditional-capture register interface (`valid` / `last` / 9-bit data). It queues write and shift commands from a local controller and drives one registered beat per cycle toward a capture register bank.
- Write beat: the bank loads the data.
- Shift beat: the bank performs its `valid==0 && last==0` update.
- Hold beat: the bank keeps its contents.

It optionally emits a merged clock-gate enable hint, so the receiver's flops can share one gating cell.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `RPT_W`, default 4: width of the shift repeat count, taken from `cmd_data[RPT_W-1:0]`; must be ≤9.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_ready`, output, 1: FIFO not full; a command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`, input, 1: 0 = WRITE, 1 = SHIFT.
- `cmd_data`, input, 9: write data for WRITE; repeat count for SHIFT (low `RPT_W` bits only).
- `valid`, output, 1: registered beat qualifier.
- `last`, output, 1: registered; 1 = hold code when `valid==0`.
- `dout`, output, 9: registered beat data.
- `busy`, output, 1: FIFO non-empty or a SHIFT burst is in progress.
- `cg_en`, output, 1: merged gate-enable hint (see Configuration).

## Operation
Beat encoding, one beat per cycle, always registered:
- WRITE: `valid=1`, `last=0`, `dout=data`.
- SHIFT: `valid=0`, `last=0`, `dout=0`.
- HOLD: `valid=0`, `last=1`, `dout=0`.

FIFO:
- `DEPTH`-entry circular buffer storing `{op, data}`.
- `cmd_ready = ~full`, combinational from the occupancy count.
- Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- When full, no push occurs even if a pop happens that cycle.

FSM states: IDLE, RUN, SHIFT.
- IDLE / RUN with FIFO empty: emit HOLD; go to IDLE.
- IDLE / RUN with FIFO non-empty: pop the head.
  - WRITE: emit a WRITE beat; go to RUN.
  - SHIFT with n≥2: emit SHIFT; load `rem = n-1`; go to SHIFT.
  - SHIFT with n=1: emit SHIFT; go to RUN.
  - SHIFT with n=0: command is consumed and emits exactly one HOLD beat; go to RUN.
- SHIFT: emit SHIFT and decrement `rem`. When `rem` reaches 1 on this beat, go to RUN. The FIFO is not popped while in SHIFT.

The output stream never contains `valid=1 && last=1`.

Reset, asynchronous on `rst` low:
- State IDLE; FIFO empty; `rem=0`.
- Output values: `valid=0`, `last=1` (HOLD), `dout=0`, `busy=0`, `cmd_ready=1`, `cg_en` as stated in Configuration.
- Reset asserted mid-burst discards queued commands and the remaining shift count immediately. No partial beat follows reset release.

## Timing
- Latency: a command accepted at edge k into an empty FIFO with the FSM not in SHIFT appears on the outputs after edge k+1.
- Throughput: back-to-back WRITEs produce one WRITE beat per cycle with no HOLD gaps.
- A SHIFT with count n occupies exactly n consecutive beat cycles (n=0 occupies one HOLD cycle). The next queued command's beat follows immediately.
- `busy` is registered. It falls after the edge that emits the final beat with the FIFO empty.
- `cmd_ready` deasserts in the same cycle the FIFO becomes full, after the pushing edge.

## Configuration
- Macro: `CG_MERGE_HINT_EN`.
- Defined:
  - `cg_en` is a flop updated alongside the beat registers, equal to `valid | ~last` of the beat being emitted.
  - This gives 1 for WRITE and SHIFT beats and 0 for HOLD.
  - Reset value 0.
  - The receiver uses it as the single merged enable for all flops sharing the if-condition.
- Not defined: `cg_en` is tied to constant 1 and no flop is instantiated.

## Test plan
- Reset release, no commands for 10 cycles -> `valid=0`, `last=1`, `dout=0`, `busy=0`, `cmd_ready=1` every cycle; `cg_en=0` with the macro, 1 without.
- Push WRITE 0x1A5, WRITE 0x003, WRITE 0x100 on consecutive edges -> three consecutive WRITE beats starting one cycle after the first accept, `dout` 0x1A5 / 0x003 / 0x100, then HOLD.
- Push SHIFT n=3 then WRITE 0x055 -> exactly 3 SHIFT beats (`valid=0`, `last=0`), then WRITE 0x055 with no gap, then HOLD; `busy` high throughout the burst.
- Push SHIFT n=0 then WRITE 0x0FF -> one HOLD beat, then WRITE 0x0FF.
- Hold `cmd_valid` with SHIFT n=15 queued first, then 4 WRITEs (`DEPTH=4`) -> `cmd_ready` drops at full; no entry is lost or duplicated; WRITE beats emerge in order after 15 SHIFT beats.
- Assert `rst` during SHIFT n=10 at beat 4 with 2 WRITEs queued -> outputs return to HOLD immediately; after release no SHIFT or WRITE beats appear; `busy=0`.

Source files
------------

// File: rtl/cond_beat_tx.sv
// Command-driven beat transmitter: queues WRITE/SHIFT commands and emits one registered valid/last/dout beat per cycle.
// Latency: a command accepted into an empty queue (not mid-burst) shows on the beat outputs one cycle after acceptance.
// Backpressure: cmd_ready = ~full; no queue pops during a SHIFT burst. Optional macro CG_MERGE_HINT_EN adds a registered cg_en.
module cond_beat_tx #(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [8:0] cmd_data,
  output logic       valid,
  output logic       last,
  output logic [8:0] dout,
  output logic       busy,
  output logic       cg_en
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [9:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [RPT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [8:0]       dout_q, dout_d;
  logic             busy_q, busy_d;

  logic             full, empty, push, pop;
  logic [9:0]       head;
  logic [RPT_W-1:0] head_n;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  // A full queue refuses the push even if the head is popped the same cycle.
  assign push      = cmd_valid & ~full;
  // The head is only consumed when the FSM is free to start a new command.
  assign pop       = (state_q != S_SHIFT) & ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign head_n    = head[RPT_W-1:0];

  // Queue storage: entries need no reset, validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
    end
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Beat selection: default is HOLD; WRITE/SHIFT beats come from the head or the running burst.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    last_d  = 1'b1;
    dout_d  = 9'd0;
    case (state_q)
      S_SHIFT: begin
        last_d = 1'b0;
        rem_d  = rem_q - RPT_ONE;
        // rem counts beats still owed including this one; 1 means this is the final beat.
        if (rem_q == RPT_ONE) state_d = S_RUN;
      end
      default: begin
        if (empty) begin
          state_d = S_IDLE;
        end else if (!head[9]) begin
          valid_d = 1'b1;
          last_d  = 1'b0;
          dout_d  = head[8:0];
          state_d = S_RUN;
        end else begin
          state_d = S_RUN;
          // A zero-count SHIFT is consumed but produces a single HOLD beat.
          if (head_n != '0) begin
            last_d = 1'b0;
            if (head_n != RPT_ONE) begin
              rem_d   = head_n - RPT_ONE;
              state_d = S_SHIFT;
            end
          end
        end
      end
    endcase
    busy_d = (count_d != '0) | (state_d == S_SHIFT);
  end

  // FSM state, burst counter, queue pointers and registered beat outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b1;
      dout_q   <= 9'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
    end
  end

  assign valid = valid_q;
  assign last  = last_q;
  assign dout  = dout_q;
  assign busy  = busy_q;

`ifdef CG_MERGE_HINT_EN
  logic cg_q, cg_d;

  // Merged gate hint: high for WRITE and SHIFT beats, low for HOLD.
  always_comb begin
    cg_d = valid_d | ~last_d;
  end

  // Gate hint register, updated alongside the beat registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cg_q <= 1'b0;
    else      cg_q <= cg_d;
  end

  assign cg_en = cg_q;
`else
  assign cg_en = 1'b1;
`endif

endmodule

// File: tb/tb_cond_beat_tx.sv
// Bench for cond_beat_tx: scoreboard of expected beats, filled when a command is accepted.
module tb_cond_beat_tx;

  localparam int DEPTH = 4;
  localparam int RPT_W = 4;
  // Beat word: {valid, last, dout}
  localparam logic [10:0] HOLD_B  = 11'h200;
  localparam logic [10:0] SHIFT_B = 11'h000;

  typedef struct {
    logic [10:0] b;
    int          due;
  } exp_t;

  logic       clk, rst, cmd_valid, cmd_ready, cmd_op;
  logic [8:0] cmd_data, dout;
  logic       valid, last, busy, cg_en;

  exp_t       exp_q[$];
  logic [9:0] cmd_q[$];
  int         cyc, acc_cnt, checks, failures;
  logic       drove, rdy_seen;

  cond_beat_tx #(.DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .valid(valid), .last(last),
    .dout(dout), .busy(busy), .cg_en(cg_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cg_of(input logic [10:0] b);
    logic r;
    r = b[10] | ~b[9];
`ifndef CG_MERGE_HINT_EN
    r = 1'b1;
`endif
    return r;
  endfunction

  function automatic void push_beats(input logic [9:0] c, input int due);
    exp_t e;
    e.due = due;
    if (!c[9]) begin
      e.b = {2'b10, c[8:0]};
      exp_q.push_back(e);
    end else if (c[RPT_W-1:0] == '0) begin
      e.b = HOLD_B;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < int'(c[RPT_W-1:0]); i++) begin
        e.b = SHIFT_B;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = 9'd0;
    drove = 1'b0; rdy_seen = 1'b0; acc_cnt = 0; cyc = 0;
    cmd_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: record the acceptance that happened at the last edge, sample the beat,
  // pop the expected beat if due, then present the next queued command.
  task automatic step(output logic [10:0] obs, output logic [10:0] expb, output logic exp_busy);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (drove && rdy_seen) begin
      push_beats(cmd_q.pop_front(), cyc + 1);
      acc_cnt++;
    end
    obs  = {valid, last, dout};
    expb = HOLD_B;
    if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      expb = e.b;
    end
    exp_busy = (exp_q.size() != 0);
    drove    = (cmd_q.size() != 0);
    rdy_seen = cmd_ready;
    cmd_valid = drove;
    cmd_op    = drove ? cmd_q[0][9]   : 1'b0;
    cmd_data  = drove ? cmd_q[0][8:0] : 9'd0;
  endtask

  task automatic test_reset();
    logic [10:0] obs, expb;
    logic        eb;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cmd_ready, cg_en} !== {HOLD_B, 1'b0, 1'b1, cg_of(HOLD_B)}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got beat=%h busy=%b rdy=%b cg=%b want beat=%h busy=0 rdy=1 cg=%b",
                 cyc, obs, busy, cmd_ready, cg_en, HOLD_B, cg_of(HOLD_B));
      end
    end
  endtask

  task automatic test_writes();
    logic [10:0] obs, expb;
    logic        eb;
    do_reset();
    cmd_q = '{10'h1A5, 10'h003, 10'h100};
    for (int i = 0; i < 8; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cg_en} !== {expb, eb, cg_of(expb)}) begin
        failures++;
        $display("FAIL writes cyc=%0d got beat=%h busy=%b cg=%b want beat=%h busy=%b cg=%b",
                 cyc, obs, busy, cg_en, expb, eb, cg_of(expb));
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_q.size() != 0) begin
      failures++;
      $display("FAIL writes_drain got pending_beats=%0d pending_cmds=%0d want 0/0", exp_q.size(), cmd_q.size());
    end
  endtask

  task automatic test_shift_burst();
    logic [10:0] obs, expb;
    logic        eb;
    do_reset();
    cmd_q = '{10'h203, 10'h055};
    for (int i = 0; i < 10; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cg_en} !== {expb, eb, cg_of(expb)}) begin
        failures++;
        $display("FAIL shift3 cyc=%0d got beat=%h busy=%b cg=%b want beat=%h busy=%b cg=%b",
                 cyc, obs, busy, cg_en, expb, eb, cg_of(expb));
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_q.size() != 0) begin
      failures++;
      $display("FAIL shift3_drain got pending_beats=%0d pending_cmds=%0d want 0/0", exp_q.size(), cmd_q.size());
    end
  endtask

  task automatic test_shift_zero();
    logic [10:0] obs, expb;
    logic        eb;
    do_reset();
    cmd_q = '{10'h200, 10'h0FF};
    for (int i = 0; i < 7; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cg_en} !== {expb, eb, cg_of(expb)}) begin
        failures++;
        $display("FAIL shift0 cyc=%0d got beat=%h busy=%b cg=%b want beat=%h busy=%b cg=%b",
                 cyc, obs, busy, cg_en, expb, eb, cg_of(expb));
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_q.size() != 0) begin
      failures++;
      $display("FAIL shift0_drain got pending_beats=%0d pending_cmds=%0d want 0/0", exp_q.size(), cmd_q.size());
    end
  endtask

  task automatic test_back_to_back_full();
    logic [10:0] obs, expb;
    logic        eb;
    logic        chk3, chk4;
    do_reset();
    chk3 = 1'b0; chk4 = 1'b0;
    cmd_q = '{10'h20F, 10'h011, 10'h022, 10'h033, 10'h044, 10'h055};
    for (int i = 0; i < 30; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cg_en} !== {expb, eb, cg_of(expb)}) begin
        failures++;
        $display("FAIL full cyc=%0d got beat=%h busy=%b cg=%b want beat=%h busy=%b cg=%b",
                 cyc, obs, busy, cg_en, expb, eb, cg_of(expb));
      end
      // SHIFT plus three WRITEs accepted: three entries queued, one slot left.
      if (acc_cnt == 4 && !chk3) begin
        chk3 = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_before_full cyc=%0d got %b want 1", cyc, cmd_ready);
        end
      end
      // Fourth WRITE accepted during the burst: queue holds DEPTH entries.
      if (acc_cnt == 5 && !chk4) begin
        chk4 = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_at_full cyc=%0d got %b want 0", cyc, cmd_ready);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || cmd_q.size() != 0 || !chk4) begin
      failures++;
      $display("FAIL full_drain got pending_beats=%0d pending_cmds=%0d full_seen=%b want 0/0/1",
               exp_q.size(), cmd_q.size(), chk4);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [10:0] obs, expb;
    logic        eb;
    int          nshift;
    do_reset();
    nshift = 0;
    cmd_q = '{10'h20A, 10'h0AA, 10'h0BB};
    for (int i = 0; i < 20 && nshift < 4; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy} !== {expb, eb}) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got beat=%h busy=%b want beat=%h busy=%b", cyc, obs, busy, expb, eb);
      end
      if (obs === SHIFT_B) nshift++;
    end
    checks++;
    if (nshift != 4) begin
      failures++;
      $display("FAIL mid_reach got shift_beats=%0d want 4", nshift);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({valid, last, dout, busy, cmd_ready, cg_en} !== {HOLD_B, 1'b0, 1'b1, cg_of(HOLD_B) & 1'b0 | ~cg_of(SHIFT_B) | cg_of(HOLD_B)}) begin
      failures++;
      $display("FAIL mid_async got beat=%h busy=%b rdy=%b cg=%b want beat=%h busy=0 rdy=1 cg=%b",
               {valid, last, dout}, busy, cmd_ready, cg_en, HOLD_B, cg_of(HOLD_B));
    end
    cmd_valid = 1'b0; drove = 1'b0; rdy_seen = 1'b0;
    cmd_q.delete(); exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(obs, expb, eb);
      checks++;
      if ({obs, busy, cmd_ready} !== {HOLD_B, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL mid_post cyc=%0d got beat=%h busy=%b rdy=%b want beat=%h busy=0 rdy=1",
                 cyc, obs, busy, cmd_ready, HOLD_B);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_writes();
    test_shift_burst();
    test_shift_zero();
    test_back_to_back_full();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
